// File: rtl/agex_mc_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | agex_mc_stage : single-issue execute stage, 1-cycle ALU/branch, iterative MUL |
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module agex_mc_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    input  logic            in_wr_reg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_wr_reg,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            busy,
    output logic [XLEN-1:0] exec_count
);

    localparam int c_STEP = XLEN / MUL_CYCLES;
    localparam int c_CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(MUL_CYCLES - 1);
    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_ADDI  = 4'd2;
    localparam logic [3:0] c_OP_LUI   = 4'd3;
    localparam logic [3:0] c_OP_AUIPC = 4'd4;
    localparam logic [3:0] c_OP_BEQ   = 4'd5;
    localparam logic [3:0] c_OP_BNE   = 4'd6;
    localparam logic [3:0] c_OP_BLT   = 4'd7;
    localparam logic [3:0] c_OP_BGE   = 4'd8;
    localparam logic [3:0] c_OP_BLTU  = 4'd9;
    localparam logic [3:0] c_OP_BGEU  = 4'd10;
    localparam logic [3:0] c_OP_JAL   = 4'd11;
    localparam logic [3:0] c_OP_JALR  = 4'd12;
    localparam logic [3:0] c_OP_MUL   = 4'd13;
    localparam logic [3:0] c_OP_MULHU = 4'd14;
    localparam logic [3:0] c_OP_NOP   = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [XLEN-1:0]     r_mcand;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_mul_hi;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_pc;
    logic [XLEN-1:0]     r_out_result;
    logic [4:0]          r_out_rd;
    logic                r_out_wr_reg;
    logic                r_br_taken;
    logic [XLEN-1:0]     r_br_target;
    logic [XLEN-1:0]     r_exec_count;

    logic                w_accept;
    logic                w_is_mul;
    logic [XLEN-1:0]     w_rs1_imm;
    logic [XLEN-1:0]     w_pc_imm;
    logic                w_eq;
    logic                w_lt_s;
    logic                w_lt_u;
    logic [XLEN-1:0]     w_result;
    logic                w_taken;
    logic [XLEN-1:0]     w_target;
    logic [XLEN+c_STEP-1:0] w_hi_ext;
    logic [XLEN+c_STEP-1:0] w_mc_ext;
    logic [XLEN+c_STEP-1:0] w_digit_ext;
    logic [XLEN+c_STEP-1:0] w_upper;
    logic [2*XLEN-1:0]   w_acc_next;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (in_op == c_OP_MUL) || (in_op == c_OP_MULHU);
    assign w_rs1_imm = in_rs1 + in_imm;
    assign w_pc_imm  = in_pc + in_imm;
    assign w_eq      = (in_rs1 == in_rs2);
    assign w_lt_s    = $signed(in_rs1) < $signed(in_rs2);
    assign w_lt_u    = in_rs1 < in_rs2;

    always_comb begin
        w_result = '0;
        w_taken  = 1'b0;
        w_target = w_pc_imm;
        case (in_op)
            c_OP_ADD:   w_result = in_rs1 + in_rs2;
            c_OP_SUB:   w_result = in_rs1 - in_rs2;
            c_OP_ADDI:  w_result = w_rs1_imm;
            c_OP_LUI:   w_result = in_imm;
            c_OP_AUIPC: w_result = w_pc_imm;
            c_OP_BEQ:   w_taken  = w_eq;
            c_OP_BNE:   w_taken  = !w_eq;
            c_OP_BLT:   w_taken  = w_lt_s;
            c_OP_BGE:   w_taken  = !w_lt_s;
            c_OP_BLTU:  w_taken  = w_lt_u;
            c_OP_BGEU:  w_taken  = !w_lt_u;
            c_OP_JAL: begin
                w_result = in_pc + c_FOUR;
                w_taken  = 1'b1;
            end
            c_OP_JALR: begin
                w_result = in_pc + c_FOUR;
                w_taken  = 1'b1;
                w_target = {w_rs1_imm[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    // Radix-2^STEP shift-add: low half holds the unconsumed multiplier digits,
    // the upper partial sum cannot exceed XLEN+STEP bits.
    assign w_hi_ext    = {{c_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]};
    assign w_mc_ext    = {{c_STEP{1'b0}}, r_mcand};
    assign w_digit_ext = {{XLEN{1'b0}}, r_acc[c_STEP-1:0]};
    assign w_upper     = w_hi_ext + w_mc_ext * w_digit_ext;

    generate
        if (c_STEP == XLEN) begin : g_single_step
            assign w_acc_next = w_upper;
        end else begin : g_multi_step
            assign w_acc_next = {w_upper, r_acc[XLEN-1:c_STEP]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_mul_hi     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_wr_reg <= 1'b0;
            r_br_taken   <= 1'b0;
            r_br_target  <= '0;
            r_exec_count <= '0;
        end else begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_exec_count <= r_exec_count + 1'b1;
                if (w_is_mul) begin
                    // Result register is empty or draining now, so it can
                    // hold the multiply's pc/rd/wr_reg until the product lands.
                    r_state      <= S_MUL;
                    r_cnt        <= '0;
                    r_mcand      <= in_rs1;
                    r_acc        <= {{XLEN{1'b0}}, in_rs2};
                    r_mul_hi     <= (in_op == c_OP_MULHU);
                    r_out_pc     <= in_pc;
                    r_out_rd     <= in_rd;
                    r_out_wr_reg <= in_wr_reg;
                end else begin
                    r_out_valid  <= 1'b1;
                    r_out_pc     <= in_pc;
                    r_out_result <= w_result;
                    r_out_rd     <= in_rd;
                    r_out_wr_reg <= in_wr_reg && (in_op != c_OP_NOP);
                    r_br_taken   <= w_taken;
                    r_br_target  <= w_taken ? w_target : '0;
                end
            end
            if (r_state == S_MUL) begin
                r_acc <= w_acc_next;
                if (r_cnt == c_LAST) begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_out_valid  <= 1'b1;
                    r_out_result <= r_mul_hi ? w_acc_next[2*XLEN-1:XLEN]
                                             : w_acc_next[XLEN-1:0];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_result = r_out_result;
    assign out_rd     = r_out_rd;
    assign out_wr_reg = r_out_wr_reg;
    assign br_taken   = r_br_taken;
    assign br_target  = r_br_target;
    assign busy       = (r_state == S_MUL);
    assign exec_count = r_exec_count;

endmodule
`default_nettype wire

// File: doc/agex_mc_stage.md
AGEX_MC_STAGE -- requirements
Module: agex_mc_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; any even value 8..64 is legal.
REQ-002 SHALL have parameter MUL_CYCLES, default 4: multiply latency in cycles; SHALL divide XLEN; 1..XLEN.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1: stage accepts this cycle.
REQ-007 SHALL have port in_op, input, 4: op code: 0 ADD, 1 SUB, 2 ADDI, 3 LUI, 4 AUIPC, 5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 BLTU, 10 BGEU, 11 JAL, 12 JALR, 13 MUL, 14 MULHU, 15 NOP.
REQ-008 SHALL have ports in_pc, in_rs1, in_rs2, in_imm, input, XLEN each: PC, operand values, sign-extended immediate.
REQ-009 SHALL have ports in_rd, input, 5 and in_wr_reg, input, 1: destination register and write enable.
REQ-010 SHALL have port out_valid, output, 1: result register holds an instruction.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have ports out_pc and out_result, output, XLEN each, plus out_rd, output, 5 and out_wr_reg, output, 1.
REQ-013 SHALL have ports br_taken, output, 1 and br_target, output, XLEN: redirect pulse and target.
REQ-014 SHALL have ports busy, output, 1 (multiply in flight) and exec_count, output, XLEN (accepted instructions).

Function
REQ-015 SHALL define accept as in_valid && in_ready, with in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-016 SHALL implement FSM states IDLE and MUL: IDLE->MUL on accept of op 13/14; MUL->IDLE when the cycle counter reaches MUL_CYCLES-1.
REQ-017 SHALL load the result register (out_valid=1) on the edge of accept for every non-multiply op: single-cycle latency.
REQ-018 SHALL compute ADD rs1+rs2; SUB rs1-rs2; ADDI rs1+imm; LUI imm; AUIPC pc+imm; JAL/JALR pc+4; branches and NOP 0; all results modulo 2^XLEN.
REQ-019 SHALL evaluate branch conditions: BLT/BGE signed two's-complement, BLTU/BGEU unsigned, BEQ/BNE equality; JAL/JALR are always taken.
REQ-020 SHALL set the target to pc+imm for branches and JAL, and to (rs1+imm) with bit 0 cleared for JALR.
REQ-021 SHALL drive br_taken high for exactly one cycle, the cycle after accepting a taken branch or jump, with br_target valid in that cycle; both SHALL be 0 in every other cycle.
REQ-022 SHALL compute multiplies iteratively on the unsigned operands, processing XLEN/MUL_CYCLES multiplier bits per cycle. MUL SHALL return product[XLEN-1:0] and MULHU SHALL return product[2XLEN-1:XLEN].
REQ-023 SHALL assert out_valid on the edge MUL_CYCLES cycles after a multiply accept. busy SHALL be 1 exactly while in state MUL.
REQ-024 SHALL clear out_valid on an edge where out_valid && out_ready and no new result loads. A simultaneous drain and load SHALL replace the contents with no bubble.
REQ-025 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-026 SHALL latch operands, pc, rd and wr_reg at multiply accept; input changes during MUL SHALL have no effect.
REQ-027 SHALL increment exec_count by 1 on each accept, wrapping from 2^XLEN-1 to 0.
REQ-028 SHALL pass NOP through with out_wr_reg forced to 0.

Reset
REQ-029 SHALL, while reset=0 and regardless of clk, force state=IDLE, counter=0, out_valid=0, br_taken=0, and busy=0. All out_* data, br_target and exec_count SHALL be 0.
REQ-030 SHALL, when reset is asserted during MUL, abandon the multiply with no result emitted. The first accept is possible in the first cycle after reset deasserts.

Verification
REQ-031 SHALL check: ADD rs1=0xFFFFFFFF, rs2=1, out_ready=1 -> next cycle out_valid=1, out_result=0, exec_count=1.
REQ-032 SHALL check: BLT rs1=0xFFFFFFFE, rs2=1, pc=0x100, imm=0x20 -> one-cycle br_taken=1, br_target=0x120; then BLTU with the same operands -> br_taken stays 0.
REQ-033 SHALL check: MUL then MULHU with rs1=rs2=0x80000001, MUL_CYCLES=4 -> in_ready=0 and busy=1 for 4 cycles, then results 0x00000001 and 0x40000001.
REQ-034 SHALL check: out_ready=0 for 3 cycles after an ADDI -> out fields stable, in_ready=0; then out_ready=1 with a new valid -> back-to-back transfer with no bubble.
REQ-035 SHALL check: JALR rs1=0x1003, imm=0, pc=0x40 -> br_target=0x1002, out_result=0x44.
REQ-036 SHALL check: reset asserted 2 cycles into a MUL -> out_valid=0 immediately, no stale result after release, and XLEN=16, MUL_CYCLES=2 repeats REQ-033 truncated to 16 bits.
